// File: rtl/pkt_id_pkg.sv
// Shared definitions for the Packet_Identifier path.
// Holds the classifier's one-hot byte-type codes, the TLP/DLLP framing
// codes fed back to the classifier, the collector state encoding and
// the bit positions inside err_pulse.
package pkt_id_pkg;

  // One-hot byte types from the K/D classifier (0 = not valid)
  localparam logic [5:0] T_DATA      = 6'b100000;
  localparam logic [5:0] T_TLPSTART  = 6'b010000;
  localparam logic [5:0] T_TLPEND    = 6'b001000;
  localparam logic [5:0] T_DLLPEND   = 6'b000100;
  localparam logic [5:0] T_DLLPSTART = 6'b000010;
  localparam logic [5:0] T_TLPEDB    = 6'b000001;

  // Framing state codes returned to the classifier
  localparam logic [1:0] FR_NONE = 2'b00;
  localparam logic [1:0] FR_TLP  = 2'b01;
  localparam logic [1:0] FR_DLLP = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IN_TLP,
    ST_IN_DLLP,
    ST_DROP
  } state_t;

  // err_pulse bit positions
  localparam int ERR_OVF = 0;
  localparam int ERR_LEN = 1;
  localparam int ERR_FRM = 2;

endpackage

// File: rtl/pkt_commit_fifo.sv
// Byte FIFO with tentative and committed write pointers.
// Bytes are written at tent_ptr; only entries below commit_ptr are
// visible to the reader. rewind discards everything written since the
// last commit.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   wr_en, wr_entry   write {kind,last,data} at tent_ptr
//   commit            with wr_en: commit_ptr follows the written entry
//   rewind            tent_ptr returns to commit_ptr (no write)
//   rd_ready          consumer accept
//   full              DEPTH entries between rd_ptr and tent_ptr
//   rd_entry,rd_valid head entry and its committed flag
module pkt_commit_fifo #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [9:0] wr_entry,
  input  logic       commit,
  input  logic       rewind,
  input  logic       rd_ready,
  output logic       full,
  output logic [9:0] rd_entry,
  output logic       rd_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  logic [9:0]  mem [DEPTH];
  logic [AW:0] rd_ptr;
  logic [AW:0] commit_ptr;
  logic [AW:0] tent_ptr;

  // Occupancy measured against the reader, so uncommitted bytes count too
  assign full     = (tent_ptr - rd_ptr) == FULL_LVL;
  assign rd_valid = (rd_ptr != commit_ptr);
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[tent_ptr[AW-1:0]] <= wr_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      commit_ptr <= '0;
      tent_ptr   <= '0;
    end else begin
      if (rewind) begin
        tent_ptr <= commit_ptr;
      end else if (wr_en) begin
        tent_ptr <= tent_ptr + PTR_ONE;
        if (commit) commit_ptr <= tent_ptr + PTR_ONE;
      end
      if (rd_valid && rd_ready) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/packet_collector.sv
// Packet collector downstream of the per-byte K/D classifier.
// Tracks TLP/DLLP framing, stages each body byte so the final one can be
// tagged `last` on END, and commits good packets into pkt_commit_fifo.
// Aborted (EDB), malformed or overflowing packets are rewound.
// Optional macro PKT_COLLECTOR_STATS_EN adds tlp_cnt/dllp_cnt/null_cnt.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   type_in, data_in     one-hot byte type and byte from the classifier
//   tlp_or_dllp_q        registered framing state fed back (01 TLP, 10 DLLP)
//   out_data/kind/last   FIFO head byte, 0=TLP 1=DLLP, final byte flag
//   out_valid, out_ready head committed / consumer accept
//   err_pulse            [0] overflow, [1] DLLP length, [2] framing
module packet_collector
  import pkt_id_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int DLLP_LEN = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] type_in,
  input  logic [7:0] data_in,
  output logic [1:0] tlp_or_dllp_q,
  output logic [7:0] out_data,
  output logic       out_kind,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] err_pulse
`ifdef PKT_COLLECTOR_STATS_EN
  ,
  output logic [15:0] tlp_cnt,
  output logic [15:0] dllp_cnt,
  output logic [15:0] null_cnt
`endif
);

  localparam logic [7:0] DLLP_LEN_B = 8'(DLLP_LEN);

  state_t     state;
  logic [7:0] stage_data;
  logic       stage_vld;
  logic [7:0] count;

  logic       in_pkt, is_start, is_data, is_end, is_edb, len_bad;
  logic       full, wr_en, wr_last, commit, rewind, ovf;
  logic [9:0] rd_entry;

  assign in_pkt   = (state == ST_IN_TLP) || (state == ST_IN_DLLP);
  assign is_start = (type_in == T_TLPSTART) || (type_in == T_DLLPSTART);
  assign is_data  = (type_in == T_DATA);
  assign is_end   = (type_in == T_TLPEND) || (type_in == T_DLLPEND);
  assign is_edb   = (type_in == T_TLPEDB);
  assign len_bad  = (state == ST_IN_DLLP) && (count != DLLP_LEN_B);

  // Overflow: the staged byte must be written but the FIFO has no room
  assign ovf = in_pkt && stage_vld && full && (is_data || (is_end && !len_bad));

  // FIFO command decode for the current byte
  always_comb begin
    wr_en   = 1'b0;
    wr_last = 1'b0;
    commit  = 1'b0;
    rewind  = 1'b0;
    if (is_edb || is_start) begin
      rewind = 1'b1;
    end else if (in_pkt && is_data) begin
      if (ovf)            rewind = 1'b1;
      else if (stage_vld) wr_en  = 1'b1;
    end else if (in_pkt && is_end) begin
      if (stage_vld && !len_bad && !full) begin
        wr_en   = 1'b1;
        wr_last = 1'b1;
        commit  = 1'b1;
      end else begin
        rewind = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      tlp_or_dllp_q <= FR_NONE;
      stage_vld     <= 1'b0;
      count         <= '0;
      err_pulse     <= '0;
    end else begin
      err_pulse <= '0;
      if (is_edb) begin
        state         <= ST_IDLE;
        tlp_or_dllp_q <= FR_NONE;
        stage_vld     <= 1'b0;
      end else if (is_start) begin
        if (in_pkt) err_pulse[ERR_FRM] <= 1'b1;
        stage_vld <= 1'b0;
        count     <= '0;
        if (type_in == T_TLPSTART) begin
          state         <= ST_IN_TLP;
          tlp_or_dllp_q <= FR_TLP;
        end else begin
          state         <= ST_IN_DLLP;
          tlp_or_dllp_q <= FR_DLLP;
        end
      end else if (in_pkt && is_data) begin
        if (ovf) begin
          err_pulse[ERR_OVF] <= 1'b1;
          state              <= ST_DROP;
          tlp_or_dllp_q      <= FR_NONE;
          stage_vld          <= 1'b0;
        end else begin
          stage_vld <= 1'b1;
          if (count != 8'hFF) count <= count + 8'd1;
        end
      end else if (in_pkt && is_end) begin
        // The packet is closed either way; an overflowing END has
        // nothing left to drop, so it returns straight to IDLE.
        state         <= ST_IDLE;
        tlp_or_dllp_q <= FR_NONE;
        stage_vld     <= 1'b0;
        if (!stage_vld)   err_pulse[ERR_FRM] <= 1'b1;
        else if (len_bad) err_pulse[ERR_LEN] <= 1'b1;
        else if (full)    err_pulse[ERR_OVF] <= 1'b1;
      end else if (state == ST_DROP && is_end) begin
        state         <= ST_IDLE;
        tlp_or_dllp_q <= FR_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_pkt && is_data && !ovf) stage_data <= data_in;
  end

`ifdef PKT_COLLECTOR_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tlp_cnt  <= '0;
      dllp_cnt <= '0;
      null_cnt <= '0;
    end else begin
      if (commit && state == ST_IN_TLP && tlp_cnt != 16'hFFFF)
        tlp_cnt <= tlp_cnt + 16'd1;
      if (commit && state == ST_IN_DLLP && dllp_cnt != 16'hFFFF)
        dllp_cnt <= dllp_cnt + 16'd1;
      if (is_edb && in_pkt && null_cnt != 16'hFFFF)
        null_cnt <= null_cnt + 16'd1;
    end
  end
`endif

  pkt_commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_entry ({state == ST_IN_DLLP, wr_last, stage_data}),
    .commit   (commit),
    .rewind   (rewind),
    .rd_ready (out_ready),
    .full     (full),
    .rd_entry (rd_entry),
    .rd_valid (out_valid)
  );

  assign {out_kind, out_last, out_data} = rd_entry;

endmodule

// File: tb/tb_packet_collector.sv
// Directed testbench for packet_collector (DEPTH = 8, DLLP_LEN = 6).
// Output transfers are captured into a queue and checked against
// hand-written {kind,last,data} entries.
module tb_packet_collector;

  localparam logic [5:0] D  = 6'b100000;
  localparam logic [5:0] TS = 6'b010000;
  localparam logic [5:0] TE = 6'b001000;
  localparam logic [5:0] DE = 6'b000100;
  localparam logic [5:0] DS = 6'b000010;
  localparam logic [5:0] EB = 6'b000001;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] type_in = '0;
  logic [7:0] data_in = '0;
  logic [1:0] tlp_or_dllp_q;
  logic [7:0] out_data;
  logic       out_kind;
  logic       out_last;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] err_pulse;

  int tests = 0;
  int fails = 0;
  logic [9:0] cap_q[$];

  packet_collector #(.DEPTH(8), .DLLP_LEN(6)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .type_in       (type_in),
    .data_in       (data_in),
    .tlp_or_dllp_q (tlp_or_dllp_q),
    .out_data      (out_data),
    .out_kind      (out_kind),
    .out_last      (out_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .err_pulse     (err_pulse)
  );

  always #5 clk = ~clk;

  // A transfer happens at the next rising edge when valid and ready hold
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) cap_q.push_back({out_kind, out_last, out_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [5:0] t, input logic [7:0] d);
    type_in = t;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(6'b0, 8'h00);
  endtask

  task automatic pop_chk(input string tag, input logic k, input logic l, input logic [7:0] d);
    logic [10:0] got;
    if (cap_q.size() == 0) got = 11'h400;
    else got = {1'b0, cap_q.pop_front()};
    chk(tag, 32'(got), 32'({1'b0, k, l, d}));
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_framing", 32'(tlp_or_dllp_q), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_err", 32'(err_pulse), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 4-byte TLP with a non-one-hot type inserted (ignored)
    step(TS, 8'h00);
    chk("tlp_q_start", 32'(tlp_or_dllp_q), 32'h1);
    step(D, 8'hAA);
    step(6'b110000, 8'hEE);
    step(D, 8'hBB);
    step(D, 8'hCC);
    step(D, 8'hDD);
    chk("tlp_q_body", 32'(tlp_or_dllp_q), 32'h1);
    chk("tlp_valid_pre", 32'(out_valid), 32'h0);
    step(TE, 8'h00);
    chk("tlp_q_end", 32'(tlp_or_dllp_q), 32'h0);
    chk("tlp_valid_lat", 32'(out_valid), 32'h1);
    chk("tlp_err", 32'(err_pulse), 32'h0);
    idle(6);
    pop_chk("tlp_b0", 1'b0, 1'b0, 8'hAA);
    pop_chk("tlp_b1", 1'b0, 1'b0, 8'hBB);
    pop_chk("tlp_b2", 1'b0, 1'b0, 8'hCC);
    pop_chk("tlp_b3", 1'b0, 1'b1, 8'hDD);
    chk("tlp_drained", 32'(cap_q.size()), 32'h0);

    // Good 6-byte DLLP, then a 5-byte DLLP
    step(DS, 8'h00);
    chk("dllp_q", 32'(tlp_or_dllp_q), 32'h2);
    for (int i = 0; i < 6; i++) step(D, 8'(8'h11 + i));
    step(DE, 8'h00);
    chk("dllp6_err", 32'(err_pulse), 32'h0);
    step(DS, 8'h00);
    for (int i = 0; i < 5; i++) step(D, 8'(8'h21 + i));
    step(DE, 8'h00);
    chk("dllp5_err", 32'(err_pulse), 32'h2);
    idle(10);
    for (int i = 0; i < 6; i++) pop_chk("dllp_b", 1'b1, (i == 5), 8'(8'h11 + i));
    chk("dllp5_absent", 32'(cap_q.size()), 32'h0);

    // EDB abort then a good 2-byte TLP
    step(TS, 8'h00);
    step(D, 8'h41);
    step(D, 8'h42);
    step(D, 8'h43);
    step(EB, 8'h00);
    chk("edb_err", 32'(err_pulse), 32'h0);
    chk("edb_q", 32'(tlp_or_dllp_q), 32'h0);
    step(TS, 8'h00);
    step(D, 8'h51);
    step(D, 8'h52);
    step(TE, 8'h00);
    chk("edb_next_err", 32'(err_pulse), 32'h0);
    idle(5);
    pop_chk("edb_b0", 1'b0, 1'b0, 8'h51);
    pop_chk("edb_b1", 1'b0, 1'b1, 8'h52);
    chk("edb_drained", 32'(cap_q.size()), 32'h0);

    // Exactly DEPTH bytes fit with no reader
    out_ready = 1'b0;
    step(TS, 8'h00);
    for (int i = 0; i < 8; i++) step(D, 8'(8'h60 + i));
    step(TE, 8'h00);
    chk("fill8_err", 32'(err_pulse), 32'h0);
    chk("fill8_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    idle(10);
    for (int i = 0; i < 8; i++) pop_chk("fill8_b", 1'b0, (i == 7), 8'(8'h60 + i));
    chk("fill8_drained", 32'(cap_q.size()), 32'h0);

    // 10-byte TLP overflows on the 9th write
    out_ready = 1'b0;
    step(TS, 8'h00);
    for (int i = 0; i < 9; i++) step(D, 8'(8'h80 + i));
    chk("ovf_pre_err", 32'(err_pulse), 32'h0);
    step(D, 8'h89);
    chk("ovf_err", 32'(err_pulse), 32'h1);
    chk("ovf_q", 32'(tlp_or_dllp_q), 32'h0);
    chk("ovf_valid", 32'(out_valid), 32'h0);
    step(TE, 8'h00);
    chk("ovf_drop_end", 32'(err_pulse), 32'h0);
    step(TS, 8'h00);
    step(D, 8'h71);
    step(D, 8'h72);
    step(TE, 8'h00);
    chk("ovf_next_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    idle(5);
    pop_chk("ovf_b0", 1'b0, 1'b0, 8'h71);
    pop_chk("ovf_b1", 1'b0, 1'b1, 8'h72);
    chk("ovf_drained", 32'(cap_q.size()), 32'h0);

    // Start inside an open packet
    step(TS, 8'h00);
    step(D, 8'h31);
    step(D, 8'h32);
    step(DS, 8'h00);
    chk("frm_err", 32'(err_pulse), 32'h4);
    chk("frm_q", 32'(tlp_or_dllp_q), 32'h2);
    for (int i = 0; i < 6; i++) step(D, 8'(8'hA0 + i));
    step(DE, 8'h00);
    chk("frm_dllp_err", 32'(err_pulse), 32'h0);
    idle(10);
    for (int i = 0; i < 6; i++) pop_chk("frm_b", 1'b1, (i == 5), 8'(8'hA0 + i));
    chk("frm_drained", 32'(cap_q.size()), 32'h0);

    // Empty packet
    step(TS, 8'h00);
    step(TE, 8'h00);
    chk("empty_err", 32'(err_pulse), 32'h4);
    idle(3);
    chk("empty_valid", 32'(out_valid), 32'h0);
    chk("empty_none", 32'(cap_q.size()), 32'h0);

    // Asynchronous reset mid-packet with 3 committed bytes unread
    out_ready = 1'b0;
    step(TS, 8'h00);
    step(D, 8'hC1);
    step(D, 8'hC2);
    step(D, 8'hC3);
    step(TE, 8'h00);
    step(TS, 8'h00);
    step(D, 8'hC4);
    chk("rstm_valid_pre", 32'(out_valid), 32'h1);
    type_in = 6'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstm_valid_async", 32'(out_valid), 32'h0);
    chk("rstm_q_async", 32'(tlp_or_dllp_q), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rstm_valid_post", 32'(out_valid), 32'h0);
    // In IDLE a data byte then END are ignored
    step(D, 8'h99);
    step(TE, 8'h00);
    chk("rstm_idle_err", 32'(err_pulse), 32'h0);
    idle(3);
    chk("rstm_idle_valid", 32'(out_valid), 32'h0);
    chk("rstm_empty", 32'(cap_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
